// File: rtl/single_cycle_mips_cpu.sv
// Single-cycle 32-bit MIPS-subset CPU: PC, instruction memory, 32x32 register
// file, ALU/shifter/optional multiplier, and word-organised data memory.
// Everything completes in one clock.
// Optional feature macro: SSCPU_MUL_EN enables funct 011000 (MUL, low 32 bits).
// IMEM_WORDS and DMEM_WORDS are expected to be powers of two so that address
// wrap-around is a plain bit slice.

module sscpu_pc (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] i_pc_next,
  output logic [31:0] pc_out_o
);
  logic [31:0] r_pc;

  // program counter register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_pc <= '0;
    else        r_pc <= i_pc_next;
  end

  assign pc_out_o = r_pc;
endmodule

module sscpu_imem #(
  parameter  int IMEM_WORDS = 64,
  localparam int IAW        = $clog2(IMEM_WORDS)
) (
  input  logic           clk_i,
  input  logic           i_ld_en,
  input  logic [IAW-1:0] i_ld_addr,
  input  logic [31:0]    i_ld_data,
  input  logic [IAW-1:0] i_addr,
  output logic [31:0]    o_instr
);
  // Never reset; contents are loaded externally by the lab harness. The load
  // port is tied off inside the CPU.
  reg [31:0] Instr_Mem [0:IMEM_WORDS-1];

  // optional program load port
  always @(posedge clk_i) begin
    if (i_ld_en) Instr_Mem[i_ld_addr] <= i_ld_data;
  end

  assign o_instr = Instr_Mem[i_addr];
endmodule

module sscpu_rf #(
  parameter int RESET_SP = 128
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);
  reg [31:0] Reg_File [0:31];

  // register file write; r0 is never written, r29 resets to the stack top
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        Reg_File[i] <= (i == 29) ? 32'(RESET_SP) : 32'd0;
    end else if (i_we && (i_wa != 5'd0)) begin
      Reg_File[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : Reg_File[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : Reg_File[i_ra2];
endmodule

module sscpu_dmem #(
  parameter  int DMEM_WORDS = 32,
  localparam int DAW        = $clog2(DMEM_WORDS)
) (
  input  logic           clk_i,
  input  logic           rst_n,
  input  logic [DAW-1:0] i_addr,
  input  logic           i_we,
  input  logic [31:0]    i_wdata,
  output logic [31:0]    o_rdata
);
  reg [31:0] memory [0:DMEM_WORDS-1];

  // word store on the clock edge, cleared by reset
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) memory[i] <= '0;
    end else if (i_we) begin
      memory[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = memory[i_addr];
endmodule

module single_cycle_mips_cpu #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32,
  parameter int RESET_SP   = 128
) (
  input  logic clk_i,
  input  logic rst_n
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_R    = 6'b000000, OP_BGEZ = 6'b000001,
                         OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ  = 6'b000100, OP_BNEZ = 6'b000101,
                         OP_BGT  = 6'b000111, OP_ADDI = 6'b001000,
                         OP_ORI  = 6'b001101, OP_LUI  = 6'b001111,
                         OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010,
                         F_SLLV = 6'b000100, F_SRLV = 6'b000110,
                         F_JR   = 6'b001000, F_MUL  = 6'b011000,
                         F_ADD  = 6'b100000, F_SUB  = 6'b100010,
                         F_AND  = 6'b100100, F_OR   = 6'b100101,
                         F_SLT  = 6'b101010;

  logic [31:0] w_pc, w_pc_next, w_pc4, w_instr;
  logic [31:0] w_rs_val, w_rt_val, w_sext, w_zext, w_br_tgt, w_j_tgt;
  logic [31:0] w_dm_addr, w_dm_rdata, w_rf_wdata;
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh, w_rf_waddr;
  logic        w_rf_we, w_dm_we;
  logic        w_unused_addr;

  sscpu_pc PC (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .i_pc_next (w_pc_next),
    .pc_out_o  (w_pc)
  );

  // fetch index wraps modulo IMEM_WORDS by taking only the low index bits
  sscpu_imem #(.IMEM_WORDS(IMEM_WORDS)) IM (
    .clk_i     (clk_i),
    .i_ld_en   (1'b0),
    .i_ld_addr ('0),
    .i_ld_data ('0),
    .i_addr    (w_pc[IAW+1:2]),
    .o_instr   (w_instr)
  );

  sscpu_rf #(.RESET_SP(RESET_SP)) RF (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rs_val),
    .o_rd2 (w_rt_val),
    .i_we  (w_rf_we),
    .i_wa  (w_rf_waddr),
    .i_wd  (w_rf_wdata)
  );

  // byte offset [1:0] dropped; word index wraps modulo DMEM_WORDS
  sscpu_dmem #(.DMEM_WORDS(DMEM_WORDS)) DM (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .i_addr  (w_dm_addr[DAW+1:2]),
    .i_we    (w_dm_we),
    .i_wdata (w_rt_val),
    .o_rdata (w_dm_rdata)
  );

  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_sh     = w_instr[10:6];
  assign w_fn     = w_instr[5:0];
  assign w_sext   = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_zext   = {16'h0, w_instr[15:0]};
  assign w_pc4    = w_pc + 32'd4;
  assign w_br_tgt = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_tgt  = {w_pc4[31:28], w_instr[25:0], 2'b00};
  assign w_dm_addr = w_rs_val + w_sext;
  assign w_unused_addr = &{1'b0, w_dm_addr[31:DAW+2], w_dm_addr[1:0]};

`ifdef SSCPU_MUL_EN
  logic [31:0] w_mul;
  assign w_mul = w_rs_val * w_rt_val;
`endif

  // decode/execute: register write, memory write and next PC
  always_comb begin
    w_pc_next  = w_pc4;
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rd;
    w_rf_wdata = '0;
    w_dm_we    = 1'b0;
    case (w_op)
      OP_R: begin
        w_rf_we = 1'b1;
        case (w_fn)
          F_ADD:  w_rf_wdata = w_rs_val + w_rt_val;
          F_SUB:  w_rf_wdata = w_rs_val - w_rt_val;
          F_AND:  w_rf_wdata = w_rs_val & w_rt_val;
          F_OR:   w_rf_wdata = w_rs_val | w_rt_val;
          F_SLT:  w_rf_wdata = {31'b0, $signed(w_rs_val) < $signed(w_rt_val)};
          // variable shifts use the whole rs value: anything >= 32 empties rt
          F_SLLV: w_rf_wdata = (w_rs_val > 32'd31) ? '0 : (w_rt_val << w_rs_val[4:0]);
          F_SRLV: w_rf_wdata = (w_rs_val > 32'd31) ? '0 : (w_rt_val >> w_rs_val[4:0]);
          F_SLL:  w_rf_wdata = w_rt_val << w_sh;
          F_SRL:  w_rf_wdata = w_rt_val >> w_sh;
`ifdef SSCPU_MUL_EN
          F_MUL:  w_rf_wdata = w_mul;
`endif
          F_JR: begin
            w_rf_we   = 1'b0;
            w_pc_next = w_rs_val;
          end
          default: w_rf_we = 1'b0;
        endcase
      end
      OP_ADDI: begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_rs_val + w_sext; end
      OP_ORI:  begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_rs_val | w_zext; end
      // LUI deliberately loads the zero-extended immediate without shifting
      OP_LUI:  begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_zext; end
      OP_LW:   begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_dm_rdata; end
      OP_SW:   w_dm_we = 1'b1;
      OP_BEQ:  if (w_rs_val == w_rt_val) w_pc_next = w_br_tgt;
      OP_BNEZ: if (w_rs_val != 32'd0)    w_pc_next = w_br_tgt;
      OP_BGT:  if (w_rs_val > w_rt_val)  w_pc_next = w_br_tgt;
      OP_BGEZ: if (!w_rs_val[31])        w_pc_next = w_br_tgt;
      OP_J:    w_pc_next = w_j_tgt;
      OP_JAL: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = 5'd31;
        w_rf_wdata = w_pc4;
        w_pc_next  = w_j_tgt;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_single_cycle_mips_cpu.sv
// Bench for single_cycle_mips_cpu: an instruction-set reference model steps
// alongside the CPU; each step's expected PC and architectural write is queued
// and a monitor compares them one cycle later. Directed program from the lab
// plan, random programs, reset and mid-program reset checks.
module tb_single_cycle_mips_cpu;
  localparam int IMW = 64;
  localparam int DMW = 32;

  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_i = ~clk_i;

  single_cycle_mips_cpu #(.IMEM_WORDS(IMW), .DMEM_WORDS(DMW), .RESET_SP(128)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    int          kind;   // 0 none, 1 register write, 2 memory write
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  logic [31:0] prog [IMW];
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DMW];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(logic [5:0] op, int t);
    return {op, 26'(t)};
  endfunction

  function automatic void m_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = (i == 29) ? 32'd128 : 32'd0;
    for (int i = 0; i < DMW; i++) m_dm[i] = 0;
  endfunction

  // Reference ISA step: architectural effect of one instruction.
  function automatic exp_t m_step();
    exp_t e;
    logic [31:0] ins, rs, rt, pc4, npc, a, wval;
    logic [5:0] op, fn;
    int rd, rti, sh, simm, widx;
    bit wr;
    ins  = prog[(m_pc >> 2) % IMW];
    op   = ins[31:26];
    fn   = ins[5:0];
    rs   = m_rf[ins[25:21]];
    rt   = m_rf[ins[20:16]];
    rti  = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    sh   = int'(ins[10:6]);
    simm = $signed(ins[15:0]);
    pc4  = m_pc + 4;
    npc  = pc4;
    wr = 0; widx = 0; wval = 0;
    e.kind = 0; e.idx = 0; e.val = 0;
    a = rs + simm;
    case (op)
      6'b000000: case (fn)
        6'b100000: begin wr = 1; widx = rd; wval = rs + rt; end
        6'b100010: begin wr = 1; widx = rd; wval = rs - rt; end
        6'b100100: begin wr = 1; widx = rd; wval = rs & rt; end
        6'b100101: begin wr = 1; widx = rd; wval = rs | rt; end
        6'b101010: begin wr = 1; widx = rd; wval = ($signed(rs) < $signed(rt)) ? 1 : 0; end
        6'b000100: begin wr = 1; widx = rd; wval = rt << rs; end
        6'b000110: begin wr = 1; widx = rd; wval = rt >> rs; end
        6'b000000: begin wr = 1; widx = rd; wval = rt << sh; end
        6'b000010: begin wr = 1; widx = rd; wval = rt >> sh; end
`ifdef SSCPU_MUL_EN
        6'b011000: begin wr = 1; widx = rd; wval = rs * rt; end
`endif
        6'b001000: npc = rs;
        default: ;
      endcase
      6'b001000: begin wr = 1; widx = rti; wval = rs + simm; end
      6'b001101: begin wr = 1; widx = rti; wval = rs | 32'(ins[15:0]); end
      6'b001111: begin wr = 1; widx = rti; wval = 32'(ins[15:0]); end
      6'b100011: begin wr = 1; widx = rti; wval = m_dm[(a >> 2) % DMW]; end
      6'b101011: begin
        m_dm[(a >> 2) % DMW] = rt;
        e.kind = 2; e.idx = int'((a >> 2) % DMW); e.val = rt;
      end
      6'b000100: if (rs == rt) npc = pc4 + simm * 4;
      6'b000101: if (rs != 0) npc = pc4 + simm * 4;
      6'b000111: if (rs > rt) npc = pc4 + simm * 4;
      6'b000001: if ($signed(rs) >= 0) npc = pc4 + simm * 4;
      6'b000010: npc = (pc4 & 32'hF000_0000) | (32'(ins[25:0]) * 4);
      6'b000011: begin
        wr = 1; widx = 31; wval = pc4;
        npc = (pc4 & 32'hF000_0000) | (32'(ins[25:0]) * 4);
      end
      default: ;
    endcase
    if (wr && widx != 0) begin
      m_rf[widx] = wval;
      e.kind = 1; e.idx = widx; e.val = wval;
    end
    m_pc = npc;
    e.pc = npc;
    return e;
  endfunction

  function automatic int rreg();
    int pick;
    pick = int'($urandom_range(0, 9));
    if (pick == 8) return 29;
    if (pick == 9) return 31;
    return pick;
  endfunction

  function automatic logic [31:0] rand_instr();
    int bi;
    bi = int'($urandom_range(0, 8)) - 4;
    case ($urandom_range(0, 23))
      0:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b100000);
      1:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b100010);
      2:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b100100);
      3:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b100101);
      4:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b101010);
      5:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b000100);
      6:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b000110);
      7:  return enc_r(0, rreg(), rreg(), int'($urandom_range(0, 31)), 6'b000000);
      8:  return enc_r(0, rreg(), rreg(), int'($urandom_range(0, 31)), 6'b000010);
      9:  return enc_r(rreg(), rreg(), rreg(), 0, 6'b011000);
      10: return enc_r(rreg(), 0, 0, 0, 6'b001000);
      11: return enc_i(6'b001000, rreg(), rreg(), int'($urandom_range(0, 65535)));
      12: return enc_i(6'b001101, rreg(), rreg(), int'($urandom_range(0, 65535)));
      13: return enc_i(6'b001111, 0, rreg(), int'($urandom_range(0, 65535)));
      14: return enc_i(6'b100011, rreg(), rreg(), int'($urandom_range(0, 65535)));
      15: return enc_i(6'b101011, rreg(), rreg(), int'($urandom_range(0, 65535)));
      16: return enc_i(6'b000100, rreg(), rreg(), bi);
      17: return enc_i(6'b000101, rreg(), rreg(), bi);
      18: return enc_i(6'b000111, rreg(), rreg(), bi);
      19: return enc_i(6'b000001, rreg(), 0, bi);
      20: return enc_j(6'b000010, int'($urandom_range(0, 63)));
      21: return enc_j(6'b000011, int'($urandom_range(0, 63)));
      22: return $urandom();
      default: return 32'd0;
    endcase
  endfunction

  task automatic load_prog();
    for (int i = 0; i < IMW; i++) dut.IM.Instr_Mem[i] = prog[i];
  endtask

  task automatic check_state(input string tag);
    chk({tag, " pc"}, dut.PC.pc_out_o, m_pc);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s r%0d", tag, i), dut.RF.Reg_File[i], m_rf[i]);
    for (int i = 0; i < DMW; i++)
      chk($sformatf("%s mem[%0d]", tag, i), dut.DM.memory[i], m_dm[i]);
  endtask

  // hold reset, load program, release on a falling edge
  task automatic restart();
    @(negedge clk_i);
    rst_n = 1'b0;
    load_prog();
    m_reset();
    #1;
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  // issue n instructions; expectations go to the scoreboard before each edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(m_step());
      @(negedge clk_i);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
      q.delete();
    end
  endtask

  // monitor: one expectation per executed instruction
  always @(posedge clk_i) begin
    exp_t e;
    if (q.size() > 0) begin
      #1;
      e = q.pop_front();
      chk("step pc", dut.PC.pc_out_o, e.pc);
      if (e.kind == 1) chk($sformatf("step r%0d", e.idx), dut.RF.Reg_File[e.idx], e.val);
      if (e.kind == 2) chk($sformatf("step mem[%0d]", e.idx), dut.DM.memory[e.idx], e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // directed lab program
    for (int i = 0; i < IMW; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(6'b001000, 0, 1, 10);          // addi r1,r0,10
    prog[1]  = enc_i(6'b001000, 0, 2, -3);          // addi r2,r0,-3
    prog[2]  = enc_r(1, 2, 3, 0, 6'b100000);        // add r3,r1,r2
    prog[3]  = enc_r(2, 1, 4, 0, 6'b100010);        // sub r4,r2,r1
    prog[4]  = enc_r(2, 1, 5, 0, 6'b101010);        // slt r5,r2,r1
    prog[5]  = enc_i(6'b001101, 0, 6, 16'hF0F0);    // ori r6,r0,0xF0F0
    prog[6]  = enc_i(6'b001111, 0, 7, 16'h1234);    // lui r7,0x1234
    prog[7]  = enc_r(0, 1, 8, 2, 6'b000000);        // sll r8,r1,2
    prog[8]  = enc_i(6'b000100, 1, 1, 2);           // 0x20 beq r1,r1 -> 0x2C
    prog[9]  = enc_i(6'b001000, 0, 20, 1);          // skipped
    prog[10] = enc_i(6'b001000, 0, 20, 1);          // skipped
    prog[11] = enc_r(0, 8, 9, 3, 6'b000010);        // srl r9,r8,3
    prog[12] = enc_r(9, 9, 10, 0, 6'b000100);       // sllv r10,r9,r9
    prog[13] = enc_r(1, 9, 11, 0, 6'b011000);       // mul r11,r1,r9
    prog[14] = enc_i(6'b101011, 29, 1, 0);          // sw r1,0(r29)
    prog[15] = enc_i(6'b101011, 29, 3, -4);         // sw r3,-4(r29)
    prog[16] = enc_j(6'b000011, 20);                // 0x40 jal 0x50
    prog[17] = enc_i(6'b100011, 29, 12, -4);        // lw r12,-4(r29)
    prog[18] = enc_i(6'b000101, 0, 0, 2);           // bnez r0 (not taken)
    prog[19] = enc_j(6'b000010, 25);                // j 0x64
    prog[20] = enc_i(6'b000111, 1, 9, 2);           // 0x50 bgt r1,r9 -> 0x5C
    prog[21] = enc_i(6'b001000, 0, 20, 1);          // skipped
    prog[22] = enc_i(6'b001000, 0, 20, 1);          // skipped
    prog[23] = enc_i(6'b000001, 2, 0, 2);           // bgez r2 (not taken)
    prog[24] = enc_r(31, 0, 0, 0, 6'b001000);       // jr r31 -> 0x44
    prog[25] = enc_j(6'b000010, 25);                // 0x64 self-loop

    #3 rst_n = 1'b0;
    load_prog();
    m_reset();
    #4;
    check_state("reset");
    @(negedge clk_i);
    rst_n = 1'b1;
    run(30);
    chk("r1", dut.RF.Reg_File[1], 32'd10);
    chk("r2", dut.RF.Reg_File[2], 32'hFFFF_FFFD);
    chk("r3", dut.RF.Reg_File[3], 32'd7);
    chk("r4", dut.RF.Reg_File[4], 32'hFFFF_FFF3);
    chk("r5", dut.RF.Reg_File[5], 32'd1);
    chk("r6", dut.RF.Reg_File[6], 32'h0000_F0F0);
    chk("r7", dut.RF.Reg_File[7], 32'h0000_1234);
    chk("r8", dut.RF.Reg_File[8], 32'd40);
    chk("r9", dut.RF.Reg_File[9], 32'd5);
    chk("r10", dut.RF.Reg_File[10], 32'd160);
`ifdef SSCPU_MUL_EN
    chk("r11", dut.RF.Reg_File[11], 32'd50);
`else
    chk("r11", dut.RF.Reg_File[11], 32'd0);
`endif
    chk("r12", dut.RF.Reg_File[12], 32'd7);
    chk("r20 skipped", dut.RF.Reg_File[20], 32'd0);
    chk("r31 link", dut.RF.Reg_File[31], 32'h44);
    chk("mem[0] wrap", dut.DM.memory[0], 32'd10);
    chk("mem[31]", dut.DM.memory[31], 32'd7);
    chk("final pc", dut.PC.pc_out_o, 32'h64);
    check_state("directed");

    // random programs
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < IMW; i++) prog[i] = rand_instr();
      restart();
      run(250);
      check_state($sformatf("rand%0d", p));
    end

    // reset asserted between edges clears state at once
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check_state("midreset");
    @(negedge clk_i);
    rst_n = 1'b1;
    run(10);
    check_state("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/single_cycle_mips_cpu.md
Name: single_cycle_mips_cpu

Overview:
- Single-cycle, 32-bit MIPS-subset processor: every instruction fetches, decodes, executes, accesses memory and writes back in one clock.
- Contains five internal units: program counter, instruction memory, 32x32 register file, ALU/shifter/multiplier, and word-organised data memory.
- Top-level block of the CPU lab; the only external pins are clock and reset.
- Verification probes internal state hierarchically, so instance and array names below are mandatory.

Parameters:
- IMEM_WORDS, 64, depth of instruction memory in 32-bit words.
- DMEM_WORDS, 32, depth of data memory in 32-bit words (128 bytes).
- RESET_SP, 128, reset value of register r29 (stack pointer).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.

Behaviour:
- Required hierarchy:
  - PC instance, with a 32-bit output pc_out_o.
  - IM instance, with reg [31:0] Instr_Mem[0:IMEM_WORDS-1]. It is loaded externally with $readmemb, is never reset, and is read combinationally at pc>>2.
  - RF instance, with reg [31:0] Reg_File[0:31].
  - DM instance, with reg [31:0] memory[0:DMEM_WORDS-1].
- Reset (rst_n=0, asynchronous):
  - PC=0.
  - All Reg_File entries 0, except r29=RESET_SP.
  - All DM words 0.
- Fetch, decode, register reads and data-memory reads are combinational. PC, RF and DM update on the same rising edge, so each instruction has a latency of one cycle.
- r0 always reads 0; writes to r0 are discarded.
- Default next PC is PC+4.
  - Branch target = PC+4 + (sign-extended imm16 << 2).
  - Jump target = {PC+4[31:28], imm26, 2'b00}.
- R-type (op 000000), by funct:
  - ADD 100000, SUB 100010: two's-complement, wrap, no overflow trap.
  - AND 100100, OR 100101.
  - SLT 101010: signed compare, result 1 or 0.
  - SLLV 000100, SRLV 000110: rd = rt shifted by the full 32-bit rs value; amount >=32 gives 0. SRLV is logical.
  - SLL 000000, SRL 000010: shift by shamt[10:6]; SRL is logical.
  - MUL 011000: rd = low 32 bits of rs*rt.
  - JR 001000: PC=rs, no register write.
  - Unknown funct: no state change, PC+4.
- I/J-type, by opcode:
  - ADDI 001000: rt = rs + sext(imm).
  - ORI 001101: rt = rs | zext(imm).
  - LUI 001111: rt = {16'h0, imm}. The immediate is zero-extended and NOT shifted; this is the decided behaviour.
  - LW 100011: rt = memory[(rs+sext(imm))>>2].
  - SW 101011: memory[(rs+sext(imm))>>2] = rt.
    - Address bits [1:0] are ignored.
    - The word index wraps modulo DMEM_WORDS.
    - The write happens on the clock edge.
  - BEQ 000100: taken if rs==rt.
  - BNEZ 000101: taken if rs!=0; rt field ignored.
  - BGT 000111: taken if rs>rt, unsigned compare.
  - BGEZ 000001: taken if rs >= 0, signed compare (i.e. rs[31]==0).
  - J 000010: PC = jump target.
  - JAL 000011: r31 = PC+4, PC = jump target.
  - Unknown opcode: treated as NOP, PC+4.
- PC beyond IMEM: the index wraps modulo IMEM_WORDS. An all-zero word decodes as SLL r0 and is therefore a NOP.
- Reset asserted mid-program: all state returns immediately to reset values. Execution restarts at address 0 after the first rising edge following deassertion.

Optional Feature:
- Macro: SSCPU_MUL_EN.
- Defined: MUL funct 011000 is implemented with a 32x32 multiplier as above.
- Undefined: funct 011000 is treated as an unknown funct (no register write, PC+4). The multiplier hardware is omitted.

Test Plan:
- Reset: hold rst_n=0, then release. Expect PC=0, r29=128, all other registers 0 and all memory words 0. Asserting rst_n=0 between clock edges clears the state immediately.
- ALU sequence:
  - addi r1,r0,10 → r1=10.
  - addi r2,r0,-3 → r2=0xFFFFFFFD.
  - add r3,r1,r2 → r3=7.
  - sub r4,r2,r1 → r4=-13.
  - slt r5,r2,r1 → r5=1.
  - ori r6,r0,0xF0F0 → r6=0x0000F0F0.
  - lui r7,0x1234 → r7=0x00001234.
- Shifts and multiply:
  - r1=10; sll r8,r1,2 → r8=40.
  - srl r9,r8,3 → r9=5.
  - sllv r10,r9,r9 → r10=160.
  - mul r11,r1,r9 → r11=50.
  - Without SSCPU_MUL_EN, r11 stays 0.
- Memory:
  - sw r1,0(r29) with r29=128 → memory index 0 (wrap) = 10.
  - sw r3,-4(r29) → memory[31]=7.
  - lw r12,-4(r29) → r12=7.
- Branches at PC=0x20, each with imm=2:
  - beq r1,r1 → next PC=0x2C.
  - bnez r0 → 0x24.
  - bgt r1,r9 (10>5) → 0x2C.
  - bgez r2 (-3) → 0x24.
- Jumps:
  - jal 0x10 at PC=0x40 → r31=0x44, PC=0x40.
  - jr r31 → PC=0x44.
  - j 0 → PC=0.
